// File: rtl/xy_route_input_unit.sv
// Router input port: flit FIFO, registered XY route stage and wormhole packet FSM.
// Routes each packet from its header, holds the port request through the tail, drops bad packets.
module xy_route_input_unit #(
   parameter int X_NODE_NUM       = 4,
   parameter int Y_NODE_NUM       = 4,
   parameter int X_NODE_NUM_WIDTH = 2,
   parameter int Y_NODE_NUM_WIDTH = 2,
   parameter int CUR_X            = 1,
   parameter int CUR_Y            = 1,
   parameter int FLIT_W           = 16,
   parameter int DEPTH            = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [FLIT_W-1:0]          in_flit,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [FLIT_W-1:0]          out_flit,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [4:0]                 out_req,
   output logic [3:0]                 port_num,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       err_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int XW = X_NODE_NUM_WIDTH;
   localparam int YW = Y_NODE_NUM_WIDTH;

   localparam logic [1:0] T_BODY   = 2'b00;
   localparam logic [1:0] T_TAIL   = 2'b01;
   localparam logic [1:0] T_HEAD   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   localparam logic [XW:0] CUR_X_V = (XW+1)'(CUR_X);
   localparam logic [YW:0] CUR_Y_V = (YW+1)'(CUR_Y);

   typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

   state_t              state, state_next;
   logic [FLIT_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count;
   logic                empty, full, push, pop, drop_pop;
   logic                load_route, clear_route;
   logic [FLIT_W-1:0]   head;
   logic [1:0]          head_type;
   logic                head_hdr, head_last;
   logic [XW-1:0]       dest_x;
   logic [YW-1:0]       dest_y;
   logic                in_range;
   logic [XW:0]         xdiff;
   logic [YW:0]         ydiff;
   logic [4:0]          route_req;
   logic [3:0]          route_port;

   assign empty      = (count == '0);
   assign full       = (count == CW'(DEPTH));
   assign in_ready   = !full;
   assign push       = in_valid && in_ready;
   assign pop        = (out_valid && out_ready) || drop_pop;
   assign fifo_count = count;

   assign head      = mem[rd_ptr];
   assign out_flit  = head;
   assign head_type = head[FLIT_W-1:FLIT_W-2];
   assign head_hdr  = (head_type == T_HEAD) || (head_type == T_SINGLE);
   assign head_last = (head_type == T_TAIL) || (head_type == T_SINGLE);
   assign dest_y    = head[YW-1:0];
   assign dest_x    = head[XW+YW-1:YW];
   assign in_range  = (int'(dest_x) < X_NODE_NUM) && (int'(dest_y) < Y_NODE_NUM);

   // Zero-extended difference; the extra top bit acts as the sign.
   assign xdiff = {1'b0, dest_x} - CUR_X_V;
   assign ydiff = {1'b0, dest_y} - CUR_Y_V;

   always_comb begin
      route_req  = 5'b00001;
      route_port = 4'd1;
      if (xdiff != '0) begin
         if (xdiff[XW]) begin
            route_req  = 5'b00100;
            route_port = 4'd4;
         end else begin
            route_req  = 5'b00010;
            route_port = 4'd2;
         end
      end else if (ydiff != '0) begin
         if (ydiff[YW]) begin
            route_req  = 5'b10000;
            route_port = 4'd3;
         end else begin
            route_req  = 5'b01000;
            route_port = 4'd5;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_flit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         out_req  <= '0;
         port_num <= '0;
      end else begin
         state <= state_next;
         if (load_route) begin
            out_req  <= route_req;
            port_num <= route_port;
         end else if (clear_route) begin
            out_req  <= '0;
            port_num <= '0;
         end
      end
   end

   // The header stays in the FIFO while routing; it leaves as the first data flit.
   always_comb begin
      state_next  = state;
      out_valid   = 1'b0;
      drop_pop    = 1'b0;
      err_drop    = 1'b0;
      load_route  = 1'b0;
      clear_route = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               if (head_hdr) begin
                  if (in_range) begin
                     load_route = 1'b1;
                     state_next = ACTIVE;
                  end else begin
                     err_drop   = 1'b1;
                     state_next = DROP;
                  end
               end else begin
                  drop_pop = 1'b1;
                  err_drop = 1'b1;
               end
            end
         end
         ACTIVE: begin
            out_valid = !empty;
            if (!empty && out_ready && head_last) begin
               clear_route = 1'b1;
               state_next  = IDLE;
            end
         end
         DROP: begin
            if (!empty) begin
               drop_pop = 1'b1;
               if (head_last) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   logic unused_types;
   assign unused_types = (T_BODY == T_TAIL);

endmodule

// File: tb/tb_xy_route_input_unit.sv
// Directed bench for xy_route_input_unit: 4x4 mesh at (1,1) plus a 3-wide instance for drops.
// Expected flits with their port request are queued on push and compared on output.
module tb_xy_route_input_unit;

   localparam int FLIT_W = 16;
   localparam int W      = FLIT_W + 9;

   logic              clk = 1'b0;
   logic              rst;
   logic [FLIT_W-1:0] in_flit;
   logic              in_valid;
   logic              in_ready;
   logic [FLIT_W-1:0] out_flit;
   logic              out_valid;
   logic              out_ready;
   logic [4:0]        out_req;
   logic [3:0]        port_num;
   logic [2:0]        fifo_count;
   logic              err_drop;

   logic [FLIT_W-1:0] in_flit3;
   logic              in_valid3;
   logic              in_ready3;
   logic [FLIT_W-1:0] out_flit3;
   logic              out_valid3;
   logic [4:0]        out_req3;
   logic [3:0]        port_num3;
   logic [2:0]        fifo_count3;
   logic              err_drop3;

   int checks = 0;
   int errors = 0;
   int err3_cnt = 0;
   int ov3_cnt = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   xy_route_input_unit dut (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
      .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready), .out_req(out_req),
      .port_num(port_num), .fifo_count(fifo_count), .err_drop(err_drop)
   );

   xy_route_input_unit #(.X_NODE_NUM(3)) dut3 (
      .clk(clk), .rst(rst), .in_flit(in_flit3), .in_valid(in_valid3), .in_ready(in_ready3),
      .out_flit(out_flit3), .out_valid(out_valid3), .out_ready(1'b1), .out_req(out_req3),
      .port_num(port_num3), .fifo_count(fifo_count3), .err_drop(err_drop3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int x, input int y,
                                            input logic [9:0] pl);
      return {t, pl, 2'(x), 2'(y)};
   endfunction

   // Reference XY decision for router (1,1): {one-hot req, port number}.
   function automatic logic [8:0] route(input int x, input int y);
      if (x > 1)      return {5'b00010, 4'd2};
      else if (x < 1) return {5'b00100, 4'd4};
      else if (y > 1) return {5'b01000, 4'd5};
      else if (y < 1) return {5'b10000, 4'd3};
      else            return {5'b00001, 4'd1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_flit(input logic [FLIT_W-1:0] f, input logic [8:0] r);
      int n;
      n = 0;
      in_flit  = f;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("push_timeout", in_ready, 1);
      exp_q.push_back({f, r});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((fifo_count != 0 || out_req != 0) && n < 100) begin
         tick();
         n++;
      end
      chk("drain_timeout", fifo_count | {2'b0, |out_req}, 0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
         else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("out_flit", out_flit, e[W-1:9]);
            chk("out_req_per_flit", out_req, e[8:4]);
            chk("port_num_per_flit", port_num, e[3:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (err_drop3)  err3_cnt++;
         if (out_valid3) ov3_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_flit = '0; in_valid = 1'b0; out_ready = 1'b0;
      in_flit3 = '0; in_valid3 = 1'b0;
      tick(); tick();
      chk("rst_out_req", out_req, 0);
      chk("rst_port_num", port_num, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err_drop", err_drop, 0);
      chk("rst_fifo_count", fifo_count, 0);
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);

      // Single flit to (3,1): east, one cycle route latency.
      push_flit(mk(2'b11, 3, 1, 10'h011), route(3, 1));
      chk("single_req_latency", out_req, 0);
      tick();
      chk("single_out_req", out_req, 5'b00010);
      chk("single_port_num", port_num, 2);
      chk("single_out_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("single_req_cleared", out_req, 0);
      chk("single_port_cleared", port_num, 0);
      chk("single_fifo_empty", fifo_count, 0);

      // Three-flit packet to (1,3), stalled for three cycles.
      push_flit(mk(2'b10, 1, 3, 10'h021), route(1, 3));
      push_flit(mk(2'b00, 0, 0, 10'h022), route(1, 3));
      push_flit(mk(2'b01, 0, 0, 10'h023), route(1, 3));
      for (int i = 0; i < 3; i++) begin
         chk("stall_count", fifo_count, 3);
         chk("stall_out_req", out_req, 5'b01000);
         chk("stall_port_num", port_num, 5);
         tick();
      end
      out_ready = 1'b1;
      wait_idle();
      out_ready = 1'b0;
      chk("pkt3_drained", exp_q.size(), 0);

      // Back-to-back single-flit packets: local then west.
      out_ready = 1'b1;
      push_flit(mk(2'b11, 1, 1, 10'h031), route(1, 1));
      push_flit(mk(2'b11, 0, 1, 10'h032), route(0, 1));
      wait_idle();
      out_ready = 1'b0;
      chk("b2b_drained", exp_q.size(), 0);

      // Fill to DEPTH; the fifth flit waits upstream.
      push_flit(mk(2'b10, 2, 1, 10'h041), route(2, 1));
      push_flit(mk(2'b00, 0, 0, 10'h042), route(2, 1));
      push_flit(mk(2'b00, 0, 0, 10'h043), route(2, 1));
      push_flit(mk(2'b00, 0, 0, 10'h044), route(2, 1));
      chk("full_count", fifo_count, 4);
      chk("full_in_ready", in_ready, 0);
      in_flit  = mk(2'b01, 0, 0, 10'h045);
      in_valid = 1'b1;
      tick();
      chk("full_held", fifo_count, 4);
      out_ready = 1'b1;
      chk("full_pop_push_refused", in_ready, 0);
      tick();
      out_ready = 1'b0;
      chk("full_after_pop", fifo_count, 3);
      chk("ready_after_pop", in_ready, 1);
      exp_q.push_back({in_flit, route(2, 1)});
      tick();
      in_valid = 1'b0;
      chk("refill_count", fifo_count, 4);
      out_ready = 1'b1;
      wait_idle();
      out_ready = 1'b0;
      chk("full_drained", exp_q.size(), 0);

      // Drops on the 3-wide instance: stray body, then out-of-range packet.
      in_flit3  = mk(2'b00, 0, 0, 10'h051);
      in_valid3 = 1'b1;
      tick();
      in_valid3 = 1'b0;
      chk("stray_err_drop", err_drop3, 1);
      tick();
      chk("stray_popped", fifo_count3, 0);
      chk("stray_pulse_end", err_drop3, 0);
      in_flit3  = mk(2'b10, 3, 1, 10'h052);
      in_valid3 = 1'b1;
      tick();
      in_flit3 = mk(2'b01, 0, 0, 10'h053);
      chk("bad_dest_err_drop", err_drop3, 1);
      tick();
      in_valid3 = 1'b0;
      chk("drop_pulse_end", err_drop3, 0);
      chk("drop_no_valid", out_valid3, 0);
      tick(); tick(); tick();
      chk("drop_fifo_empty", fifo_count3, 0);
      chk("drop_err_pulses", err3_cnt, 2);
      chk("drop_valid_cycles", ov3_cnt, 0);

      // Asynchronous reset in the middle of a packet heading north.
      push_flit(mk(2'b10, 1, 0, 10'h061), route(1, 0));
      push_flit(mk(2'b00, 0, 0, 10'h062), route(1, 0));
      chk("mid_out_req", out_req, 5'b10000);
      chk("mid_port_num", port_num, 3);
      #2;
      rst = 1'b1;
      #1;
      chk("async_out_req", out_req, 0);
      chk("async_port_num", port_num, 0);
      chk("async_fifo_count", fifo_count, 0);
      chk("async_out_valid", out_valid, 0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      chk("post_rst_in_ready", in_ready, 1);
      push_flit(mk(2'b11, 1, 2, 10'h071), route(1, 2));
      tick();
      chk("post_rst_out_req", out_req, 5'b01000);
      chk("post_rst_port_num", port_num, 5);
      out_ready = 1'b1;
      wait_idle();
      out_ready = 1'b0;
      chk("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/xy_route_input_unit.md
Name: xy_route_input_unit

Overview:
- Parametrised successor to the fixed-coordinate XY route computer: one router input port with an input flit FIFO, a registered XY route stage and a wormhole packet-state FSM.
- Sits between a link receiver and the crossbar/switch allocator of a mesh router.
- Per packet: computes the output port from the header flit, holds that port request for every flit up to and including the tail, and drops malformed or unroutable packets with an error pulse.

Parameters:
- X_NODE_NUM, 4, mesh width in nodes (>=2)
- Y_NODE_NUM, 4, mesh height in nodes (>=2)
- X_NODE_NUM_WIDTH, 2, bits of x coordinate (ceil log2 X_NODE_NUM)
- Y_NODE_NUM_WIDTH, 2, bits of y coordinate (ceil log2 Y_NODE_NUM)
- CUR_X, 1, this router's x address
- CUR_Y, 1, this router's y address
- FLIT_W, 16, flit width; bits [FLIT_W-1:FLIT_W-2] = flit type
- DEPTH, 4, FIFO entries, power of two >=2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_flit  in  FLIT_W  incoming flit
- in_valid  in  1  in_flit valid
- in_ready  out  1  FIFO can accept (= !full)
- out_flit  out  FLIT_W  FIFO head flit toward crossbar
- out_valid  out  1  head flit presentable (ACTIVE state and !empty)
- out_ready  in  1  switch grant/accept for this cycle
- out_req  out  5  one-hot port request: bit0 L, bit1 E, bit2 W, bit3 S, bit4 N
- port_num  out  4  encoded port of current packet: L=1, E=2, N=3, W=4, S=5, 0 = none
- fifo_count  out  log2(DEPTH)+1  occupancy
- err_drop  out  1  one-cycle pulse when a packet (or stray flit) is discarded

Behaviour:
- Flit types: 2'b10 header, 2'b00 body, 2'b01 tail, 2'b11 single-flit (header+tail).
- Destination fields in the header: dest_y = flit[Y_NODE_NUM_WIDTH-1:0]; dest_x = flit[X_NODE_NUM_WIDTH+Y_NODE_NUM_WIDTH-1:Y_NODE_NUM_WIDTH].
- Route arithmetic: signed, width+1 bits. xdiff = dest_x - CUR_X; ydiff = dest_y - CUR_Y.
  - xdiff>0: E; xdiff<0: W.
  - Otherwise ydiff>0: S; ydiff<0: N; else L.
- FIFO:
  - Push on in_valid && in_ready; pop on out_valid && out_ready, or on a DROP-state pop.
  - Simultaneous push and pop when not full keeps the count unchanged.
  - When full, in_ready=0 even if a pop occurs the same cycle (no pass-through).
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, ACTIVE, DROP:
  - IDLE, FIFO empty: stay.
  - IDLE, head is header/single with dest_x<X_NODE_NUM and dest_y<Y_NODE_NUM: register port_num and out_req, go to ACTIVE. Head is not popped. Route latency is 1 cycle, so out_req is visible the cycle after the header reaches the head.
  - IDLE, head is header/single with out-of-range dest: go to DROP, pulse err_drop.
  - IDLE, head is body/tail (stray): pop it, pulse err_drop, stay IDLE.
  - ACTIVE: out_req and port_num stay held, including across FIFO-empty bubbles where out_valid=0. On a pop of a tail or single flit, go to IDLE and clear out_req/port_num on the next edge. A back-to-back header is therefore routed the cycle after it reaches the head.
  - DROP: out_valid=0; pop one flit per cycle while !empty; return to IDLE after popping a tail/single flit.
- A header arriving in ACTIVE is treated as data; integrity is the upstream router's responsibility.
- Reset (asynchronous, any time including mid-packet):
  - FIFO emptied, state IDLE.
  - out_req=0, port_num=0, out_valid=0, err_drop=0, fifo_count=0.
  - in_ready=1 once reset is deasserted; out_flit is don't-care.

Test Plan:
- CUR=(1,1), 4x4 mesh. Single flit 2'b11 with dest x=3,y=1 (low nibble 4'b1101) -> out_req=5'b00010, port_num=2 one cycle after the head; flit out on out_ready; FSM back to IDLE, out_req=0.
- 3-flit packet (header dest x=1,y=3, body, tail), out_ready held 0 for 3 cycles -> out_req=5'b01000, port_num=5 held throughout; flits exit in order once out_ready=1; FIFO stays at 3 while stalled.
- Header dest (1,1) then header dest (0,1) back-to-back -> first out_req=5'b00001 (L, port_num=1), then 5'b00100 (W, port_num=4); no flit is lost.
- DEPTH=4, out_ready=0, push 5 flits -> in_ready falls after the 4th, fifo_count=4; the 5th is held upstream; pop+push same cycle still refused while full.
- Stray body flit, then a header with dest_x=3 under X_NODE_NUM=3 followed by its tail -> err_drop pulses once per event; no out_valid; FSM ends in IDLE.
- Assert rst mid-packet in ACTIVE -> out_req=0, port_num=0, fifo_count=0 asynchronously; the next header routes normally.
